instr_sequencer: RTL and testbench

Multi-cycle controller for the 16-bit datapath.
- Holds the instruction register (IR) and decodes the instruction.
- Drives the datapath strobes (register file read/write, A/B/C/status loads, operand selects, shifter and ALU op) as a Moore FSM.
- Sits directly upstream of the ALU stage and sequences operand fetch, execute and writeback, one instruction at a time.

---
 rtl/instr_pkg.sv | 49 ++++
 rtl/instr_sequencer_if.sv | 40 ++++
 rtl/instr_decoder.sv | 48 ++++
 rtl/instr_sequencer.sv | 140 ++++++++++++++
 tb/tb_instr_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
// Holds the state encoding, opcode fields and sign-extend helpers.
package instr_pkg;

  localparam int DW   = 16;
  localparam int RN_W = 3;

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    WR_IMM,
    GET_A,
    GET_B,
    EXEC,
    CMP_ST,
    WRITE_RD
  } state_e;

  typedef enum logic [2:0] {
    CLS_UNDEF,
    CLS_MOVI,
    CLS_MOVR,
    CLS_ARITH,
    CLS_CMP,
    CLS_MVN
  } cls_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  function automatic logic [DW-1:0] sext8(input logic [7:0] v);
    return {{(DW-8){v[7]}}, v};
  endfunction

  function automatic logic [DW-1:0] sext5(input logic [4:0] v);
    return {{(DW-5){v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-in / datapath-strobe-out bundle of the sequencer.
// The sequencer is the slave; whoever feeds instructions is the master.
interface instr_sequencer_if;
  import instr_pkg::*;

  logic            s;
  logic            load;
  logic [DW-1:0]   in;
  logic            w;
  logic [RN_W-1:0] nsel_num;
  logic            write;
  logic [1:0]      vsel;
  logic            loada;
  logic            loadb;
  logic            loadc;
  logic            loads;
  logic            asel;
  logic            bsel;
  logic [1:0]      shift;
  logic [1:0]      ALUop;
  logic [DW-1:0]   sximm8;
  logic [DW-1:0]   sximm5;

  modport master (
    output s, load, in,
    input  w, nsel_num, write, vsel,
    input  loada, loadb, loadc, loads,
    input  asel, bsel, shift, ALUop,
    input  sximm8, sximm5
  );

  modport slave (
    input  s, load, in,
    output w, nsel_num, write, vsel,
    output loada, loadb, loadc, loads,
    output asel, bsel, shift, ALUop,
    output sximm8, sximm5
  );

endinterface

// File: rtl/instr_decoder.sv
// Pure combinational split of the instruction register into fields,
// instruction class and sign-extended immediates.
module instr_decoder
  import instr_pkg::*;
(
  input  logic [DW-1:0]   ir_i,
  output logic [RN_W-1:0] rn_o,
  output logic [RN_W-1:0] rd_o,
  output logic [RN_W-1:0] rm_o,
  output logic [1:0]      op_o,
  output logic [1:0]      sh_o,
  output cls_e            cls_o,
  output logic [DW-1:0]   sximm8_o,
  output logic [DW-1:0]   sximm5_o
);

  logic [2:0] opc;
  logic is_movi, is_movr, is_arith, is_cmp, is_mvn;

  assign opc      = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = sext8(ir_i[7:0]);
  assign sximm5_o = sext5(ir_i[4:0]);

  assign is_movi  = (opc == OPC_MOV) && (op_o == OP_MOVI);
  assign is_movr  = (opc == OPC_MOV) && (op_o == OP_MOVR);
  assign is_arith = (opc == OPC_ALU)
                 && ((op_o == OP_ADD) || (op_o == OP_AND));
  assign is_cmp   = (opc == OPC_ALU) && (op_o == OP_CMP);
  assign is_mvn   = (opc == OPC_ALU) && (op_o == OP_MVN);

  always_comb begin
    cls_o = CLS_UNDEF;
    unique case (1'b1)
      is_movi:  cls_o = CLS_MOVI;
      is_movr:  cls_o = CLS_MOVR;
      is_arith: cls_o = CLS_ARITH;
      is_cmp:   cls_o = CLS_CMP;
      is_mvn:   cls_o = CLS_MVN;
      default:  cls_o = CLS_UNDEF;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Moore controller: holds IR and steps one instruction at a time
// through operand fetch, execute and writeback.
module instr_sequencer
  import instr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.slave   bus
);

  state_e          state_q, state_d;
  logic [DW-1:0]   ir_q, ir_d;

  logic [RN_W-1:0] rn, rd, rm;
  logic [1:0]      op, sh;
  cls_e            cls;
  logic [DW-1:0]   sx8, sx5;

  logic [RN_W-1:0] nsel;
  logic [1:0]      vsel, alu_op;
  logic            wr, la, lb, lc, ls, asel, bsel;

  instr_decoder u_dec (
    .ir_i     (ir_q),
    .rn_o     (rn),
    .rd_o     (rd),
    .rm_o     (rm),
    .op_o     (op),
    .sh_o     (sh),
    .cls_o    (cls),
    .sximm8_o (sx8),
    .sximm5_o (sx5)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR only moves while idle, so it is stable for the whole instruction
  always_comb begin
    ir_d = ir_q;
    if (state_q == WAIT && bus.load) ir_d = bus.in;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT:     if (bus.s) state_d = DECODE;
      DECODE: begin
        unique case (cls)
          CLS_MOVI:          state_d = WR_IMM;
          CLS_ARITH, CLS_CMP: state_d = GET_A;
          CLS_MOVR, CLS_MVN:  state_d = GET_B;
          default:           state_d = WAIT;
        endcase
      end
      WR_IMM:   state_d = WAIT;
      GET_A:    state_d = GET_B;
      GET_B:    state_d = (cls == CLS_CMP) ? CMP_ST : EXEC;
      EXEC:     state_d = WRITE_RD;
      CMP_ST:   state_d = WAIT;
      WRITE_RD: state_d = WAIT;
      default:  state_d = WAIT;
    endcase
  end

  always_comb begin
    nsel   = '0;
    vsel   = VSEL_C;
    alu_op = op;
    wr     = 1'b0;
    la     = 1'b0;
    lb     = 1'b0;
    lc     = 1'b0;
    ls     = 1'b0;
    asel   = 1'b0;
    bsel   = 1'b0;
    unique case (state_q)
      WR_IMM: begin
        nsel = rn;
        vsel = VSEL_IMM;
        wr   = 1'b1;
      end
      GET_A: begin
        nsel = rn;
        la   = 1'b1;
      end
      GET_B: begin
        nsel = rm;
        lb   = 1'b1;
      end
      EXEC: begin
        lc = 1'b1;
        if (cls == CLS_MOVR) begin
          asel   = 1'b1;
          alu_op = 2'b00;
        end
      end
      CMP_ST: begin
        alu_op = OP_CMP;
        ls     = 1'b1;
      end
      WRITE_RD: begin
        nsel = rd;
        wr   = 1'b1;
      end
      default: ;
    endcase
    // strobes are killed for the whole reset cycle, whatever the state
    if (reset) begin
      wr = 1'b0;
      la = 1'b0;
      lb = 1'b0;
      lc = 1'b0;
      ls = 1'b0;
    end
  end

  assign bus.w        = (state_q == WAIT);
  assign bus.nsel_num = nsel;
  assign bus.write    = wr;
  assign bus.vsel     = vsel;
  assign bus.loada    = la;
  assign bus.loadb    = lb;
  assign bus.loadc    = lc;
  assign bus.loads    = ls;
  assign bus.asel     = asel;
  assign bus.bsel     = bsel;
  assign bus.shift    = sh;
  assign bus.ALUop    = alu_op;
  assign bus.sximm8   = sx8;
  assign bus.sximm5   = sx5;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: latency table, per-step
// micro-op model with random instructions, and reset/handshake corners.
module tb_instr_sequencer;
  import instr_pkg::*;

  logic clk = 1'b0;
  logic reset;

  instr_sequencer_if bus();

  instr_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // snapshot layout: w,write,la,lb,lc,ls,asel,bsel | nsel[6:4] | vsel[3:2] | alu[1:0]
  function automatic logic [14:0] snap();
    return {bus.w, bus.write, bus.loada, bus.loadb, bus.loadc,
            bus.loads, bus.asel, bus.bsel, bus.nsel_num, bus.vsel,
            bus.ALUop};
  endfunction

  localparam logic [14:0] M_BASE = 15'h7F80;
  localparam logic [14:0] M_NSEL = 15'h0070;
  localparam logic [14:0] M_VSEL = 15'h000C;
  localparam logic [14:0] M_ALU  = 15'h0003;

  function automatic logic [14:0] mk(
    logic wr, logic la, logic lb, logic lc, logic ls, logic as,
    logic [2:0] ns, logic [1:0] vs, logic [1:0] al);
    return {1'b0, wr, la, lb, lc, ls, as, 1'b0, ns, vs, al};
  endfunction

  logic [14:0] e_q[$];
  logic [14:0] m_q[$];

  // micro-op schedule of one instruction, one entry per non-idle cycle
  task automatic build(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    opc = ir[15:13]; op = ir[12:11];
    rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
    e_q.delete(); m_q.delete();
    e_q.push_back('0); m_q.push_back(M_BASE);
    if (opc == 3'b110 && op == 2'b10) begin
      e_q.push_back(mk(1,0,0,0,0,0,rn,2'b10,0));
      m_q.push_back(M_BASE | M_NSEL | M_VSEL);
    end else if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) begin
      if (opc == 3'b101 && op != 2'b11) begin
        e_q.push_back(mk(0,1,0,0,0,0,rn,0,0));
        m_q.push_back(M_BASE | M_NSEL);
      end
      e_q.push_back(mk(0,0,1,0,0,0,rm,0,0));
      m_q.push_back(M_BASE | M_NSEL);
      if (opc == 3'b101 && op == 2'b01) begin
        e_q.push_back(mk(0,0,0,0,1,0,0,0,2'b01));
        m_q.push_back(M_BASE | M_ALU);
      end else begin
        if (opc == 3'b110)
          e_q.push_back(mk(0,0,0,1,0,1,0,0,2'b00));
        else
          e_q.push_back(mk(0,0,0,1,0,0,0,0,op));
        m_q.push_back(M_BASE | M_ALU);
        e_q.push_back(mk(1,0,0,0,0,0,rd,2'b00,0));
        m_q.push_back(M_BASE | M_NSEL | M_VSEL);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_model(input logic [15:0] ir, input bit both,
                           input bit junk);
    logic [14:0] a;
    check("idle_w", bus.w, 1'b1);
    bus.in = ir; bus.load = 1'b1; bus.s = both;
    step();
    if (!both) begin
      bus.load = 1'b0; bus.s = 1'b1;
      step();
    end
    bus.load = 1'b0; bus.s = 1'b0;
    build(ir);
    for (int i = 0; i < e_q.size(); i++) begin
      if (junk) begin
        bus.load = 1'($urandom); bus.s = 1'($urandom);
        bus.in = 16'($urandom);
      end
      a = snap();
      check($sformatf("step%0d_%h", i, ir), a & m_q[i], e_q[i] & m_q[i]);
      step();
    end
    bus.load = 1'b0; bus.s = 1'b0; bus.in = '0;
    check($sformatf("done_w_%h", ir), bus.w, 1'b1);
    check($sformatf("imm_%h", ir), {bus.sximm8, bus.sximm5},
          {{8{ir[7]}}, ir[7:0], {11{ir[4]}}, ir[4:0]});
    check($sformatf("shift_%h", ir), bus.shift, ir[4:3]);
  endtask

  typedef struct {
    logic [15:0] in;
    int          lat;
    logic        wrote;
    logic [15:0] sx8;
    logic [15:0] sx5;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;
    logic wrote;

    vecs[0] = '{16'hD1FE, 3, 1'b1, 16'hFFFE, 16'hFFFE};
    vecs[1] = '{16'hA148, 6, 1'b1, 16'h0048, 16'h0008};
    vecs[2] = '{16'hA900, 5, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{16'hB861, 5, 1'b1, 16'h0061, 16'h0001};
    vecs[4] = '{16'hC048, 5, 1'b1, 16'h0048, 16'h0008};
    vecs[5] = '{16'h0000, 2, 1'b0, 16'h0000, 16'h0000};
    vecs[6] = '{16'hE0FF, 2, 1'b0, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{16'hB0F3, 6, 1'b1, 16'hFFF3, 16'hFFF3};

    reset = 1'b1; bus.s = 1'b0; bus.load = 1'b0; bus.in = '0;
    step();
    check("rst_strobes", {bus.write, bus.loada, bus.loadb,
          bus.loadc, bus.loads}, 5'b0);
    step();
    reset = 1'b0;
    check("rst_w", bus.w, 1'b1);
    check("rst_ir", bus.sximm8, 16'h0000);
    step();
    check("idle_strobes", {bus.write, bus.loada, bus.loadb,
          bus.loadc, bus.loads}, 5'b0);

    run_model(16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      bus.in = vecs[i].in; bus.load = 1'b1;
      step();
      bus.load = 1'b0; bus.s = 1'b1;
      step();
      bus.s = 1'b0;
      cnt = 0; wrote = 1'b0;
      while (!bus.w && cnt < 20) begin
        wrote |= bus.write;
        step();
        cnt++;
      end
      check($sformatf("lat_%h", vecs[i].in), cnt + 1, vecs[i].lat);
      check($sformatf("wrote_%h", vecs[i].in), wrote, vecs[i].wrote);
      check($sformatf("sx_%h", vecs[i].in), {bus.sximm8, bus.sximm5},
            {vecs[i].sx8, vecs[i].sx5});
    end

    run_model(16'hD1FE, 1'b0, 1'b0);
    run_model(16'hA148, 1'b0, 1'b0);
    run_model(16'hA900, 1'b1, 1'b0);
    run_model(16'hB861, 1'b0, 1'b1);
    run_model(16'hC048, 1'b1, 1'b1);

    // s held high restarts straight after returning to WAIT
    bus.in = 16'hD205; bus.load = 1'b1; bus.s = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    step();
    check("hold_s_wait", bus.w, 1'b1);
    step();
    check("hold_s_restart", bus.w, 1'b0);
    bus.s = 1'b0;
    step();
    check("hold_s_wrimm", {bus.write, bus.nsel_num}, {1'b1, 3'd2});
    step();
    check("hold_s_end", bus.w, 1'b1);

    // load ignored mid-instruction, then reset during EXEC
    bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
    step();
    bus.load = 1'b0; bus.s = 1'b0;
    step();
    step();
    bus.in = 16'hD007; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("mid_exec_loadc", bus.loadc, 1'b1);
    check("mid_ir_kept", bus.sximm8, 16'h0048);
    reset = 1'b1;
    #1;
    check("mid_rst_strobes", {bus.write, bus.loada, bus.loadb,
          bus.loadc, bus.loads}, 5'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_w", bus.w, 1'b1);
    check("mid_rst_ir", bus.sximm8, 16'h0000);
    step();

    for (int i = 0; i < 60; i++) begin
      logic [15:0] ir;
      int r;
      ir = 16'($urandom);
      r = $urandom_range(0, 3);
      if (r == 0) ir[15:13] = 3'b110;
      else if (r != 3) ir[15:13] = 3'b101;
      run_model(ir, 1'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
